// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: programmable pattern table stepped by a single-clock
// prescaler tick, with loop / one-shot / ping-pong / freeze play modes.
module led_pattern_seq #(
  parameter int LED_W   = 5,
  parameter int NSTEPS  = 8,
  parameter int DIV_W   = 27,
  parameter int DIV_RST = 2**25,
  parameter int IW      = $clog2(NSTEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_in,
  input  logic             len_wr,
  input  logic [IW:0]      len_in,
  input  logic             tbl_wr,
  input  logic [IW-1:0]    tbl_addr,
  input  logic [LED_W-1:0] tbl_data,
  output logic [LED_W-1:0] led,
  output logic [IW-1:0]    step,
  output logic             tick,
  output logic             heartbeat,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] M_LOOP    = 2'b00;
  localparam logic [1:0] M_ONESHOT = 2'b01;
  localparam logic [1:0] M_PING    = 2'b10;

  state_t           state, state_nx;
  logic [IW-1:0]    step_nx;
  logic             dir_r, dir_nx;
  logic [DIV_W-1:0] div, cnt, eff_div;
  logic [IW:0]      len, eff_len;
  logic [IW-1:0]    last;
  logic [LED_W-1:0] tbl [NSTEPS];

  function automatic logic [LED_W-1:0] init_entry(input int i);
    logic [31:0] v;
    case (i)
      1:       v = 32'b01010;
      2:       v = 32'b00100;
      3:       v = 32'b01110;
      4:       v = 32'b10001;
      default: v = '0;
    endcase
    return v[LED_W-1:0];
  endfunction

  // Prescaler: divide of 0 behaves like 1 (tick every cycle)
  assign eff_div = (div == '0) ? DIV_W'(1) : div;
  assign tick    = (cnt == eff_div - DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= DIV_W'(DIV_RST);
      cnt       <= '0;
      heartbeat <= 1'b0;
    end else begin
      if (tick) heartbeat <= ~heartbeat;
      if (div_wr) begin
        div <= div_in;
        cnt <= '0;
      end else if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  always_comb begin
    eff_len = len;
    if (len == '0)                    eff_len = (IW+1)'(1);
    else if (len > (IW+1)'(NSTEPS))   eff_len = (IW+1)'(NSTEPS);
  end
  assign last = IW'(eff_len - (IW+1)'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) len <= (IW+1)'(NSTEPS);
    else if (len_wr) len <= len_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSTEPS; i++) tbl[i] <= init_entry(i);
    end else if (tbl_wr && (int'(tbl_addr) < NSTEPS)) begin
      tbl[tbl_addr] <= tbl_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      dir_r <= 1'b0;
      led   <= '0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      dir_r <= dir_nx;
      led   <= tbl[step];
    end
  end

  // A step beyond last (after a length shrink) re-enters at the start of the
  // current direction before any end-of-sequence handling.
  always_comb begin
    state_nx = state;
    step_nx  = step;
    dir_nx   = dir_r;
    if (start) begin
      state_nx = RUN;
      step_nx  = dir ? last : '0;
      dir_nx   = dir;
    end else if (stop) begin
      state_nx = IDLE;
    end else if (state == RUN && tick) begin
      case (mode)
        M_LOOP: begin
          if (!dir_r) step_nx = (step >= last) ? '0 : step + 1'b1;
          else        step_nx = (step == '0 || step > last) ? last : step - 1'b1;
        end
        M_ONESHOT: begin
          if (!dir_r) begin
            if (step > last)       step_nx  = '0;
            else if (step == last) state_nx = DONE;
            else                   step_nx  = step + 1'b1;
          end else begin
            if (step > last)       step_nx  = last;
            else if (step == '0)   state_nx = DONE;
            else                   step_nx  = step - 1'b1;
          end
        end
        M_PING: begin
          if (last == '0) begin
            step_nx = '0;
          end else if (!dir_r) begin
            if (step > last) begin
              step_nx = '0;
            end else if (step == last) begin
              dir_nx  = 1'b1;
              step_nx = last - 1'b1;
            end else begin
              step_nx = step + 1'b1;
            end
          end else begin
            if (step > last) begin
              step_nx = last;
            end else if (step == '0) begin
              dir_nx  = 1'b0;
              step_nx = IW'(1);
            end else begin
              step_nx = step - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: reset defaults, play modes, prescaler
// corner cases, table writes and asynchronous reset mid-run.
module tb_led_pattern_seq;
  localparam int LED_W = 5;
  localparam int NSTEPS = 8;
  localparam int DIV_W = 27;
  localparam int IW = 3;

  localparam logic [4:0] LOOP_LED [8] = '{5'b00000, 5'b01010, 5'b00100, 5'b01110,
                                          5'b10001, 5'b00000, 5'b00000, 5'b00000};
  localparam logic [2:0] PP_STEP [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic dir = 1'b0, div_wr = 1'b0, len_wr = 1'b0, tbl_wr = 1'b0;
  logic [DIV_W-1:0] div_in = '0;
  logic [IW:0] len_in = '0;
  logic [IW-1:0] tbl_addr = '0;
  logic [LED_W-1:0] tbl_data = '0;
  logic [LED_W-1:0] led;
  logic [IW-1:0] step;
  logic tick, heartbeat, busy, done;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  led_pattern_seq #(.LED_W(LED_W), .NSTEPS(NSTEPS), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .dir(dir),
    .div_wr(div_wr), .div_in(div_in), .len_wr(len_wr), .len_in(len_in),
    .tbl_wr(tbl_wr), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .led(led), .step(step), .tick(tick), .heartbeat(heartbeat),
    .busy(busy), .done(done)
  );

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_strobes;
    start = 0; stop = 0; div_wr = 0; len_wr = 0; tbl_wr = 0;
  endtask

  task automatic test_reset;
    rst = 1; nclk(2);
    total++;
    if ({step, led} !== '0) $display("FAIL reset_step_led step=%0d led=%b exp 0/00000", step, led);
    else passed++;
    total++;
    if ({tick, heartbeat, busy, done} !== 4'b0000)
      $display("FAIL reset_flags tick/hb/busy/done=%b exp 0000", {tick, heartbeat, busy, done});
    else passed++;
    rst = 0; nclk(1);
  endtask

  task automatic test_loop;
    div_in = 3; div_wr = 1; mode = 2'b00; dir = 0; start = 1;
    nclk(1); clear_strobes;
    for (int k = 0; k <= 8; k++) begin
      total++;
      if (step !== 3'(k % 8) || heartbeat !== 1'(k % 2) || busy !== 1'b1)
        $display("FAIL loop_step k=%0d step=%0d hb=%b busy=%b exp %0d/%0d/1", k, step, heartbeat, busy, k % 8, k % 2);
      else passed++;
      nclk(1);
      total++;
      if (led !== LOOP_LED[k % 8]) $display("FAIL loop_led k=%0d led=%b exp %b", k, led, LOOP_LED[k % 8]);
      else passed++;
      if (k < 8) begin
        nclk(1);
        total++;
        if (tick !== 1'b1) $display("FAIL loop_tick k=%0d tick=%b exp 1", k, tick);
        else passed++;
        nclk(1);
      end
    end
    stop = 1; nclk(1); clear_strobes;
    total++;
    if (busy !== 1'b0 || step !== 3'd0) $display("FAIL loop_stop busy=%b step=%0d exp 0/0", busy, step);
    else passed++;
  endtask

  task automatic test_oneshot;
    len_in = 5; len_wr = 1; div_in = 1; div_wr = 1; mode = 2'b01; dir = 1;
    nclk(1); clear_strobes;
    start = 1; nclk(1); start = 0;
    total++;
    if (step !== 3'd4 || busy !== 1'b1) $display("FAIL oneshot_start step=%0d busy=%b exp 4/1", step, busy);
    else passed++;
    for (int k = 1; k <= 4; k++) begin
      nclk(1);
      total++;
      if (step !== 3'(4 - k) || busy !== 1'b1) $display("FAIL oneshot_step step=%0d busy=%b exp %0d/1", step, busy, 4 - k);
      else passed++;
    end
    for (int k = 0; k < 2; k++) begin
      nclk(1);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || step !== 3'd0)
        $display("FAIL oneshot_done done=%b busy=%b step=%0d exp 1/0/0", done, busy, step);
      else passed++;
    end
    start = 1; nclk(1); start = 0;
    total++;
    if (step !== 3'd4 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL oneshot_restart step=%0d busy=%b done=%b exp 4/1/0", step, busy, done);
    else passed++;
  endtask

  task automatic test_pingpong;
    stop = 1; len_in = 4; len_wr = 1; mode = 2'b10; dir = 0;
    nclk(1); clear_strobes;
    start = 1; nclk(1); start = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) nclk(1);
      total++;
      if (step !== PP_STEP[k]) $display("FAIL pingpong_step k=%0d step=%0d exp %0d", k, step, PP_STEP[k]);
      else passed++;
    end
    len_in = 1; len_wr = 1; nclk(1); len_wr = 0;
    for (int k = 0; k < 3; k++) begin
      nclk(1);
      total++;
      if (step !== 3'd0) $display("FAIL pingpong_len1 step=%0d exp 0", step);
      else passed++;
    end
  endtask

  task automatic test_prescaler;
    rst = 1; nclk(1); rst = 0; clear_strobes; mode = 2'b00; dir = 0;
    div_in = 0; div_wr = 1; nclk(1); div_wr = 0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (tick !== 1'b1 || heartbeat !== 1'(k % 2))
        $display("FAIL div0_tick k=%0d tick=%b hb=%b exp 1/%0d", k, tick, heartbeat, k % 2);
      else passed++;
      if (k < 3) nclk(1);
    end
    div_in = 7; div_wr = 1; nclk(1); div_wr = 0;
    nclk(2);
    div_in = 5; div_wr = 1; start = 1; dir = 1;
    nclk(1); clear_strobes;
    total++;
    if (step !== 3'd7 || busy !== 1'b1 || tick !== 1'b0)
      $display("FAIL divwr_start step=%0d busy=%b tick=%b exp 7/1/0", step, busy, tick);
    else passed++;
    for (int k = 1; k <= 3; k++) begin
      nclk(1);
      total++;
      if (tick !== 1'b0) $display("FAIL divwr_early_tick k=%0d tick=%b exp 0", k, tick);
      else passed++;
    end
    nclk(1);
    total++;
    if (tick !== 1'b1 || step !== 3'd7) $display("FAIL divwr_tick tick=%b step=%0d exp 1/7", tick, step);
    else passed++;
    start = 1; dir = 1; nclk(1); start = 0;
    total++;
    if (step !== 3'd7) $display("FAIL start_on_tick step=%0d exp 7", step);
    else passed++;
    nclk(4);
    total++;
    if (tick !== 1'b1 || step !== 3'd7) $display("FAIL next_tick tick=%b step=%0d exp 1/7", tick, step);
    else passed++;
    nclk(1);
    total++;
    if (step !== 3'd6) $display("FAIL tick_advance step=%0d exp 6", step);
    else passed++;
  endtask

  task automatic test_table;
    stop = 1; div_in = 1; div_wr = 1; mode = 2'b00; dir = 0;
    nclk(1); clear_strobes;
    start = 1; nclk(1); start = 0;
    nclk(2);
    mode = 2'b11; nclk(1);
    total++;
    if (step !== 3'd2) $display("FAIL freeze_step step=%0d exp 2", step);
    else passed++;
    tbl_wr = 1; tbl_addr = 3'd2; tbl_data = 5'b11111; nclk(1); tbl_wr = 0;
    total++;
    if (step !== 3'd2 || led !== 5'b00100) $display("FAIL table_before step=%0d led=%b exp 2/00100", step, led);
    else passed++;
    nclk(1);
    total++;
    if (led !== 5'b11111) $display("FAIL table_write led=%b exp 11111", led);
    else passed++;
  endtask

  task automatic test_reset_midrun;
    mode = 2'b00; stop = 1; tbl_wr = 1; tbl_addr = 3'd3; tbl_data = 5'b10101;
    len_in = 7; len_wr = 1;
    nclk(1); clear_strobes;
    start = 1; dir = 0; nclk(1); start = 0;
    nclk(4);
    total++;
    if (step !== 3'd4 || led !== 5'b10101) $display("FAIL midrun_entry3 step=%0d led=%b exp 4/10101", step, led);
    else passed++;
    nclk(2);
    total++;
    if (step !== 3'd6 || busy !== 1'b1) $display("FAIL midrun_step6 step=%0d busy=%b exp 6/1", step, busy);
    else passed++;
    #2 rst = 1;
    #1;
    total++;
    if (step !== 3'd0 || led !== 5'b00000 || busy !== 1'b0 || done !== 1'b0 || tick !== 1'b0 || heartbeat !== 1'b0)
      $display("FAIL async_reset step=%0d led=%b busy=%b done=%b tick=%b hb=%b exp all 0",
               step, led, busy, done, tick, heartbeat);
    else passed++;
    @(negedge clk); rst = 0;
    start = 1; dir = 1; nclk(1); start = 0;
    total++;
    if (step !== 3'd7 || tick !== 1'b0) $display("FAIL reset_len step=%0d tick=%b exp 7/0", step, tick);
    else passed++;
    stop = 1; len_in = 4; len_wr = 1; nclk(1); clear_strobes;
    start = 1; dir = 1; nclk(1); start = 0;
    total++;
    if (step !== 3'd3) $display("FAIL reset_restart step=%0d exp 3", step);
    else passed++;
    nclk(1);
    total++;
    if (led !== 5'b01110 || tick !== 1'b0) $display("FAIL reset_table led=%b tick=%b exp 01110/0", led, tick);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_loop();
    test_oneshot();
    test_pingpong();
    test_prescaler();
    test_table();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
